// File: rtl/frame_writer_pkg.sv
// Shared definitions for the camera frame writer: FSM encoding, RGB565 field
// positions inside the {hi, lo} byte pair, and sticky error bit indices.
package frame_writer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SYNC      = 3'd1,
        WAIT_LINE = 3'd2,
        BYTE_HI   = 3'd3,
        BYTE_LO   = 3'd4
    } state_t;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    localparam int ERR_LINE_OVF = 0;
    localparam int ERR_ODD_BYTE = 1;

endpackage

// File: rtl/frame_writer_rgb565_unpack.sv
// Splits an RGB565 byte pair into R, G, B and keeps the CH_W most significant
// bits of each channel, packed as {R, G, B}.
module rgb565_unpack
    import frame_writer_pkg::*;
#(
    parameter int CH_W = 5
) (
    input  logic [7:0]        hi,
    input  logic [7:0]        lo,
    output logic [3*CH_W-1:0] rgb
);

    logic [15:0]        word;
    logic [R_HI-R_LO:0] r_full;
    logic [G_HI-G_LO:0] g_full;
    logic [B_HI-B_LO:0] b_full;
    logic               unused_bits;

    assign word   = {hi, lo};
    assign r_full = word[R_HI:R_LO];
    assign g_full = word[G_HI:G_LO];
    assign b_full = word[B_HI:B_LO];

    assign rgb = {r_full[R_HI-R_LO -: CH_W],
                  g_full[G_HI-G_LO -: CH_W],
                  b_full[B_HI-B_LO -: CH_W]};

    // Truncated LSBs are intentionally dropped.
    assign unused_bits = ^{r_full, g_full, b_full};

endmodule

// File: rtl/frame_writer.sv
// Captures an 8-bit RGB565 camera stream into a (decimated) frame buffer,
// with ping-pong banking, frame counting and sticky framing errors.
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int DECIM      = 1,
    parameter int CH_W       = 5,
    parameter int DOUBLE_BUF = 1,
    parameter int ADDR_W     = 19
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              en,
    input  logic              vsync,
    input  logic              href,
    input  logic              pclk_rise,
    input  logic [7:0]        d,
    input  logic              err_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3*CH_W-1:0] wr_data,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              busy,
    output logic [1:0]        err
);

    localparam int COL_W = $clog2(H_RES + 1);
    localparam int ROW_W = $clog2(V_RES + 1);
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_RES);
    localparam logic [COL_W-1:0]  COL_MASK  = COL_W'(DECIM - 1);
    localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(V_RES);
    localparam logic [ROW_W-1:0]  ROW_MASK  = ROW_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES / DECIM);

    state_t              state;
    logic [1:0]          rst_sync;
    logic                rst_n;
    logic                vsync_q;
    logic [7:0]          hi_q;
    logic                pix_ok;
    logic                abort_q;
    logic                wrote_any;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [ADDR_W-1:0]   px_addr;
    logic [ADDR_W-1:0]   line_base;
    logic [ADDR_W-1:0]   line_next;
    logic [3*CH_W-1:0]   pix_rgb;
    logic                vsync_rise, vsync_fall;
    logic                in_byte, col_ok, row_ok, row_take, px_take;
    logic                lo_strobe, line_end;
    logic [1:0]          err_set;

    // Assertion is immediate, release is aligned to CLK.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    rgb565_unpack #(.CH_W(CH_W)) u_unpack (
        .hi  (hi_q),
        .lo  (d),
        .rgb (pix_rgb)
    );

    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;
    assign busy       = (state == WAIT_LINE) || (state == BYTE_HI) || (state == BYTE_LO);
    assign in_byte    = (state == BYTE_HI) || (state == BYTE_LO);
    assign col_ok     = col < COL_END;
    assign row_ok     = row < ROW_END;
    assign row_take   = row_ok && ((row & ROW_MASK) == '0);
    assign px_take    = row_take && col_ok && ((col & COL_MASK) == '0);
    assign lo_strobe  = (state == BYTE_LO) && href && pclk_rise && !vsync_rise;
    assign line_end   = in_byte && !href;
    assign line_next  = line_base + LINE_STEP;

    // NOTE: always_comb outputs get a default first so no path can infer a latch.
    always_comb begin
        err_set = '0;
        err_set[ERR_LINE_OVF] = lo_strobe && !col_ok && row_ok;
        err_set[ERR_ODD_BYTE] = (state == BYTE_LO) && !href && !vsync_rise;
    end

    // NOTE: all state updates are non-blocking so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            hi_q       <= '0;
            pix_ok     <= 1'b0;
            abort_q    <= 1'b0;
            wrote_any  <= 1'b0;
            col        <= '0;
            row        <= '0;
            px_addr    <= '0;
            line_base  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err        <= '0;
        end else begin
            vsync_q    <= vsync;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            err        <= (err & ~{2{err_clr}}) | err_set;
            if (busy && !en) abort_q <= 1'b1;

            case (state)
                IDLE: if (en) state <= SYNC;
                SYNC: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (vsync_fall) begin
                        state     <= WAIT_LINE;
                        col       <= '0;
                        row       <= '0;
                        px_addr   <= '0;
                        line_base <= '0;
                        wrote_any <= 1'b0;
                        abort_q   <= 1'b0;
                    end
                end
                default: begin
                    if (vsync_rise) begin
                        // A disabled frame ends silently and leaves the banks alone.
                        if (abort_q || !en) begin
                            state <= IDLE;
                        end else begin
                            state <= SYNC;
                            if (wrote_any) begin
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 16'd1;
                                rd_bank    <= wr_bank;
                                if (DOUBLE_BUF != 0) wr_bank <= ~wr_bank;
                            end
                        end
                    end else if (state == WAIT_LINE) begin
                        if (href) begin
                            state <= BYTE_HI;
                            col   <= '0;
                        end
                    end else if (line_end) begin
                        state <= WAIT_LINE;
                        if (row_ok) row <= row + ROW_W'(1);
                        if (row_take) begin
                            line_base <= line_next;
                            px_addr   <= line_next;
                        end else begin
                            px_addr   <= line_base;
                        end
                    end else if (state == BYTE_HI) begin
                        if (pclk_rise) begin
                            state  <= BYTE_LO;
                            hi_q   <= d;
                            pix_ok <= en && !abort_q;
                        end
                    end else if (lo_strobe) begin
                        state <= BYTE_HI;
                        if (col_ok) col <= col + COL_W'(1);
                        if (px_take) begin
                            px_addr <= px_addr + ADDR_W'(1);
                            if (pix_ok) begin
                                wr_en     <= 1'b1;
                                wr_addr   <= px_addr;
                                wr_data   <= pix_rgb;
                                wrote_any <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 The block SHALL have parameter H_RES, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_RES, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter DECIM, default 1, meaning spatial decimation factor; legal values are 1, 2 and 4.
REQ-004 The block SHALL have parameter CH_W, default 5, meaning stored bits per colour channel; legal range is 1..5.
REQ-005 The block SHALL have parameter DOUBLE_BUF, default 1, meaning ping-pong banking enabled (1) or single bank (0).
REQ-006 The block SHALL have parameter ADDR_W, default 19, meaning write address width, with ADDR_W >= clog2(H_RES*V_RES/DECIM^2).
REQ-007 The block SHALL have port CLK, input, 1 bit, the single clock; one clock, all logic on its rising edge.
REQ-008 The block SHALL have port RESETn, input, 1 bit, reset that is asynchronous and active-low.
REQ-009 The block SHALL have the following inputs: en (1 bit, capture enable); vsync, href, pclk_rise (1 bit each, camera controls already synchronised to CLK, with pclk_rise a one-cycle strobe per camera byte); d (8 bits, camera byte, valid when pclk_rise=1); err_clr (1 bit, clears sticky errors).
REQ-010 The block SHALL have the following outputs: wr_en (1 bit); wr_addr (ADDR_W bits); wr_data (3*CH_W bits, packed {R,G,B}); wr_bank (1 bit); rd_bank (1 bit, last completed bank); frame_done (1 bit pulse); frame_cnt (16 bits); busy (1 bit); err (2 bits, [0]=line overflow, [1]=odd byte count).

Function
REQ-011 The FSM SHALL have exactly the states IDLE, SYNC, WAIT_LINE, BYTE_HI, BYTE_LO.
- IDLE -> SYNC when en=1.
- SYNC -> WAIT_LINE on the falling edge of vsync (frame start); col, row and addr are set to 0.
- WAIT_LINE -> BYTE_HI when href=1.
- BYTE_HI -> BYTE_LO on pclk_rise with href=1.
- BYTE_LO -> BYTE_HI on pclk_rise with href=1.
- BYTE_HI or BYTE_LO -> WAIT_LINE when href falls; row increments.
- Any state other than IDLE -> SYNC when vsync rises (frame end).
REQ-012 In BYTE_HI the block SHALL latch d; in BYTE_LO the pixel SHALL be formed as R=hi[7:3], G=hi[2:0]:d[7:5] (6 bits), B=d[4:0], and each channel SHALL be truncated to its CH_W MSBs (G to the MSBs of its 6 bits).
- Worked example with CH_W=5: hi=0xF8, d=0x1F gives R=0x1F, G=0x00, B=0x1F, so wr_data=0x7C1F.
REQ-013 A pixel SHALL be written only when col%DECIM==0, row%DECIM==0, col<H_RES and row<V_RES.
- The write address SHALL be (row/DECIM)*(H_RES/DECIM)+col/DECIM.
- The address SHALL be generated incrementally, with no multiplier.
REQ-014 wr_en SHALL be a one-cycle pulse, registered, asserted on the cycle after the pclk_rise that completes the pixel; wr_addr and wr_data SHALL be valid in that same cycle.
REQ-015 Pixels with col>=H_RES SHALL be discarded and set err[0]; lines with row>=V_RES SHALL be discarded silently.
REQ-016 If href falls while in BYTE_LO (half pixel pending), the byte SHALL be discarded and err[1] set.
REQ-017 err bits SHALL be sticky until err_clr=1.
- If err_clr and a new error occur in the same cycle, set wins.
REQ-018 At each frame end (vsync rise out of WAIT_LINE, BYTE_HI or BYTE_LO) where at least one pixel was written, the block SHALL:
- pulse frame_done for one cycle;
- increment frame_cnt, wrapping 0xFFFF->0;
- set rd_bank=wr_bank, then toggle wr_bank if DOUBLE_BUF=1.
REQ-019 If en falls mid-frame, the current pixel SHALL complete, the block SHALL return to IDLE at the next frame end without frame_done, and banks SHALL be unchanged.
REQ-020 busy SHALL be 1 in every state except IDLE and SYNC.
REQ-021 pclk_rise while href=0 SHALL be ignored.

Reset
REQ-022 While RESETn=0, state=IDLE and wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, rd_bank=0, frame_done=0, frame_cnt=0, busy=0, err=0.
REQ-023 Reset assertion SHALL take effect asynchronously; deassertion SHALL be used synchronised to CLK, and the first frame is captured only after a full vsync high->low sequence.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, the RGB565 field positions, and the err bit indices.
REQ-025 A sub-module rgb565_unpack (combinational byte pair to truncated {R,G,B}) SHALL be instantiated once; all counters and the FSM SHALL remain in frame_writer.

Verification (H_RES=8, V_RES=4, CH_W=5 unless stated)
REQ-026 Bench SHALL cover the following directed scenarios:
- Full frame, DECIM=1, 4 lines of 16 bytes: 32 wr_en pulses at addresses 0..31, frame_done once, frame_cnt=1, rd_bank=0, wr_bank=1.
- Pixel bytes 0xF8,0x1F: wr_data=0x7C1F one cycle after the second pclk_rise.
- DECIM=2: 8 writes at addresses 0..7 (rows 0 and 2, cols 0,2,4,6).
- A line of 20 bytes: err[0]=1 and addresses never exceed 31; err_clr=1 returns err to 0.
- A line of 15 bytes: err[1]=1 and 7 writes on that line; en dropped mid-frame: no frame_done, return to IDLE.
- RESETn pulsed low mid-line: all outputs zero immediately; the next pixel is written only after a new vsync fall.
